// File: rtl/memoria_de_instrucoes_carregavel_if.sv
// Byte-wide loader handshake between a boot source (master) and the loadable instruction memory (slave).
// carregar starts a load, byte_valido/byte_pronto move one byte per edge, fim_carga closes the program.
interface memoria_de_instrucoes_carregavel_if;
    logic       carregar;
    logic [7:0] byte_entrada;
    logic       byte_valido;
    logic       byte_pronto;
    logic       fim_carga;

    modport master (
        output carregar,
        output byte_entrada,
        output byte_valido,
        output fim_carga,
        input  byte_pronto
    );

    modport slave (
        input  carregar,
        input  byte_entrada,
        input  byte_valido,
        input  fim_carga,
        output byte_pronto
    );
endinterface

// File: rtl/memoria_de_instrucoes_carregavel.sv
// Instruction memory filled at run time from a byte stream (MSB byte first); fetch reads NOP until a load completes.
// Latency: fetch is combinational from pc; with MEM_LEITURA_REGISTRADA_EN defined it is registered (1 cycle).
// Backpressure: byte_pronto is high only while loading; bytes offered outside a load are refused.
module memoria_de_instrucoes_carregavel #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                                     clock,
    input  logic                                     reset,
    memoria_de_instrucoes_carregavel_if.slave        carga,
    input  logic [ADDR_WIDTH-1:0]                    pc,
    output logic [DATA_WIDTH-1:0]                    instrucao,
    output logic                                     pronto,
    output logic                                     erro,
    output logic [ADDR_WIDTH:0]                      palavras_carregadas
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BI_W-1:0]     ULTIMO  = BI_W'(BYTES - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CARGA  = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [DATA_WIDTH-1:0]   buffer_q, buffer_d;
    logic [BI_W-1:0]         indice_q, indice_d;
    logic [ADDR_WIDTH:0]     palavras_q, palavras_d;
    logic                    erro_q, erro_d;
    logic                    cheio_q, cheio_d;
    logic                    transfere;
    logic                    escreve;
    logic [DATA_WIDTH-1:0]   palavra_nova;
    logic                    visivel;
    logic [IDX_W-1:0]        pc_idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign transfere = (estado_q == CARGA) && carga.byte_valido;

    always_comb begin
        estado_d     = estado_q;
        buffer_d     = buffer_q;
        indice_d     = indice_q;
        palavras_d   = palavras_q;
        erro_d       = erro_q;
        cheio_d      = cheio_q;
        escreve      = 1'b0;
        palavra_nova = buffer_q;

        // The buffer starts each word at zero, so a short final word comes out already padded.
        for (int k = 0; k < BYTES; k++) begin
            if (transfere && (indice_q == BI_W'(k))) begin
                palavra_nova[(BYTES-1-k)*8 +: 8] = carga.byte_entrada;
            end
        end

        case (estado_q)
            CARGA: begin
                if (transfere) begin
                    indice_d = indice_q + 1'b1;
                    buffer_d = palavra_nova;
                end
                escreve = (transfere && (indice_q == ULTIMO)) ||
                          (carga.fim_carga && (transfere || (indice_q != '0)));
                if (escreve) begin
                    palavras_d = palavras_q + 1'b1;
                    indice_d   = '0;
                    buffer_d   = '0;
                end
                if (carga.fim_carga) begin
                    estado_d = PRONTO;
                    indice_d = '0;
                    buffer_d = '0;
                end else if (escreve && (palavras_d == DEPTH_W)) begin
                    // Memory full without an end marker: any further byte is an overflow.
                    estado_d = PRONTO;
                    cheio_d  = 1'b1;
                end
            end
            OCIOSO, PRONTO: begin
                if (carga.carregar) begin
                    estado_d   = CARGA;
                    buffer_d   = '0;
                    indice_d   = '0;
                    palavras_d = '0;
                    erro_d     = 1'b0;
                    cheio_d    = 1'b0;
                end else if ((estado_q == PRONTO) && cheio_q && carga.byte_valido) begin
                    erro_d = 1'b1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            buffer_q   <= '0;
            indice_q   <= '0;
            palavras_q <= '0;
            erro_q     <= 1'b0;
            cheio_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            buffer_q   <= buffer_d;
            indice_q   <= indice_d;
            palavras_q <= palavras_d;
            erro_q     <= erro_d;
            cheio_q    <= cheio_d;
        end
    end

    always_ff @(posedge clock) begin
        if (escreve) begin
            mem[palavras_q[IDX_W-1:0]] <= palavra_nova;
        end
    end

    assign pc_idx  = pc[IDX_W-1:0];
    assign visivel = (estado_q == PRONTO) && ({1'b0, pc} < palavras_q);

`ifdef MEM_LEITURA_REGISTRADA_EN
    logic [DATA_WIDTH-1:0] instrucao_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instrucao_q <= '0;
        end else begin
            instrucao_q <= visivel ? mem[pc_idx] : '0;
        end
    end

    assign instrucao = instrucao_q;
`else
    assign instrucao = visivel ? mem[pc_idx] : '0;
`endif

    assign carga.byte_pronto   = (estado_q == CARGA);
    assign pronto              = (estado_q == PRONTO);
    assign erro                = erro_q;
    assign palavras_carregadas = palavras_q;
endmodule

// File: doc/memoria_de_instrucoes_carregavel.md
# memoria_de_instrucoes_carregavel

Parametrised instruction memory for the iZero datapath that is filled at run time through a byte-wide loader handshake instead of fixed initial contents. The fetch stage drives `pc` and reads `instrucao`. A boot source, such as the switch/UART input path, streams program bytes through a load FSM. The FSM assembles bytes into words and writes them to consecutive addresses. Fetch output is forced to NOP until a load completes.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width; must be a multiple of 8.
- `ADDR_WIDTH`, 8, width of `pc`.
- `DEPTH`, 256, number of words; must be ≤ 2^ADDR_WIDTH.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_WIDTH  fetch address.
- `instrucao`  out  DATA_WIDTH  fetched instruction.
- `carregar`  in  1  single-cycle pulse that starts a load at address 0.
- `byte_entrada`  in  8  program byte, MSB byte of each word first.
- `byte_valido`  in  1  `byte_entrada` is valid.
- `byte_pronto`  out  1  memory accepts a byte this cycle.
- `fim_carga`  in  1  end-of-program marker from the boot source.
- `pronto`  out  1  program loaded; fetch enabled.
- `erro`  out  1  sticky overflow flag: a byte arrived beyond `DEPTH` words.
- `palavras_carregadas`  out  ADDR_WIDTH+1  number of words written by the last or current load.

## Operation
- FSM states:
  - `OCIOSO` (reset state).
  - `CARGA`.
  - `PRONTO`.
- Transitions:
  - `OCIOSO`/`PRONTO` → `CARGA` on `carregar`. This clears the word counter, byte index and `erro`; it also deasserts `pronto`.
  - `CARGA` → `PRONTO` when `fim_carga` is sampled high.
  - `CARGA` → `PRONTO` when the `DEPTH`-th word is written and `fim_carga` has not arrived. This transition sets `erro` only if a further byte is then offered while in `PRONTO` before the next `carregar`. That byte is refused (`byte_pronto`=0) and `erro` sets on the first such `byte_valido`.
  - `carregar` while in `CARGA` is ignored.
- Handshake:
  - `byte_pronto` = 1 exactly in `CARGA`.
  - A byte transfers on a rising edge where `byte_valido` & `byte_pronto`.
  - The source may hold `byte_valido` high back-to-back, one byte per cycle.
- Assembly:
  - Bytes shift into a DATA_WIDTH/8-byte buffer, MSB first.
  - When the last byte of a word transfers, the full word is written to `mem[palavras_carregadas]` and the counter increments.
- `fim_carga` with a partial word:
  - The received bytes occupy the high bytes; the remaining low bytes are zero.
  - The padded word is written and counted.
- `fim_carga` together with a byte transfer: the byte is accepted first, then the word is finalised with that byte included.
- Fetch:
  - `instrucao` = `mem[pc]` when `pronto`=1 and `pc` < `palavras_carregadas`.
  - Otherwise `instrucao` = 0 (NOP).
  - Unwritten or stale locations are never exposed.
- Memory contents are not cleared by reset or `carregar`; only the counter gates visibility.

## Timing
- Reset values: state `OCIOSO`, `instrucao`=0, `byte_pronto`=0, `pronto`=0, `erro`=0, `palavras_carregadas`=0.
- Reset asserted mid-load aborts immediately, and the load must be restarted.
- A word write takes effect on the edge of its last byte. `palavras_carregadas` updates on the same edge.
- `pronto` rises on the edge after the final byte is accepted (or after the edge sampling `fim_carga`). The first valid fetch is visible in that following cycle.
- `carregar` takes one cycle to enter `CARGA`; `byte_pronto` rises on the next edge.

## Configuration
- `MEM_LEITURA_REGISTRADA_EN` defined:
  - `instrucao` is registered: it reflects the `pc` sampled on the previous rising edge (1-cycle read latency, maps to block RAM).
  - The gating conditions are evaluated at sample time.
  - Reset clears the output register to 0.
- Undefined: `instrucao` is combinational from `pc` (zero latency, matches the current single-cycle fetch).

## Test plan
- Reset, then `pc`=0..3 → `instrucao`=0; `pronto`=0, `byte_pronto`=0, `palavras_carregadas`=0.
- Pulse `carregar`, stream bytes 0x80,0x00,0x00,0x00,0xF8,0x00,0x00,0x00, then pulse `fim_carga` → `palavras_carregadas`=2, `pronto`=1. Checks:
  - `pc`=0 → 0x80000000.
  - `pc`=1 → 0xF8000000.
  - `pc`=2 → 0.
- Send 0x12,0x34 with `fim_carga` asserted alongside 0x34 → word 0x12340000 at address 0, `palavras_carregadas`=1.
- `DEPTH`=4: stream 16 bytes, then offer a 17th → `pronto`=1 after word 3 and `byte_pronto`=0. Also `erro`=1 and `palavras_carregadas`=4.
- Drop `byte_valido` randomly mid-word, and assert `reset` low during `CARGA` after 5 bytes. Required response:
  - No byte is lost or duplicated on gaps.
  - Reset → all outputs return to reset values asynchronously.
  - A subsequent full load succeeds.
- With `MEM_LEITURA_REGISTRADA_EN` defined: after loading, change `pc` 0→1 → `instrucao` changes one edge later.
